// File: rtl/ltl_symbol_encoder_pkg.sv
// Shared types and constants for the LTL runtime-monitor symbol encoder.
package ltl_enc_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARM    = 2'd1,
      S_STREAM = 2'd2,
      S_DRAIN  = 2'd3
   } enc_state_e;

   localparam int SYM_W_DEF = 8;
   localparam int CNT_W     = 32;

endpackage

// File: rtl/ltl_symbol_encoder_if.sv
// Proposition-vector handshake between the CVA6 core (master) and the encoder (slave).
interface ltl_symbol_encoder_if
   import ltl_enc_pkg::*;
#(
   parameter int SYM_W = SYM_W_DEF
);
   logic             ap_valid_i;
   logic [SYM_W-1:0] ap_i;
   logic             ap_ready_o;

   modport master (output ap_valid_i, output ap_i, input ap_ready_o);
   modport slave  (input ap_valid_i, input ap_i, output ap_ready_o);
endinterface

// File: rtl/ltl_symbol_encoder_fifo.sv
// Synchronous symbol FIFO; pointers carry an extra wrap bit to tell full from empty.
// A push on a full FIFO is accepted when a pop happens in the same cycle; clear wins over push.
module ltl_sym_fifo #(
   parameter int DEPTH = 8,
   parameter int SYM_W = 8
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [SYM_W-1:0] wdata,
   output logic [SYM_W-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [SYM_W-1:0] r_mem [DEPTH];
   logic             w_do_pop;
   logic             w_do_push;

   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);
   assign rdata     = r_mem[r_rd_ptr[AW-1:0]];

   // Pointer update: clear discards contents, otherwise advance on push/pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_do_push && !clear) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/ltl_symbol_encoder.sv
// LTL symbol encoder: buffers proposition vectors and sequences the automaton
// reset so the first symbol lands in its start-of-data cycle.
// Optional stutter compression is enabled by defining LTL_ENC_DEDUP_EN.
module ltl_symbol_encoder
   import ltl_enc_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int SYM_W      = SYM_W_DEF,
   parameter int RST_CYCLES = 2
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable_i,
   input  logic                 flush_i,
   ltl_symbol_encoder_if.slave  ap_if,
   output logic                 aut_reset_o,
   output logic                 aut_run_o,
   output logic [SYM_W-1:0]     aut_symbols_o,
   output logic                 busy_o,
   output logic                 ovf_o,
   output logic [CNT_W-1:0]     sym_count_o
);
   enc_state_e       r_state;
   enc_state_e       w_state_nxt;
   logic [CNT_W-1:0] r_rst_cnt;
   logic [CNT_W-1:0] r_sym_cnt;
   logic             r_aut_reset;
   logic             r_aut_run;
   logic [SYM_W-1:0] r_aut_sym;
   logic             r_ovf;
   logic             w_full;
   logic             w_empty;
   logic             w_active;
   logic             w_accept;
   logic             w_arm;
   logic             w_push;
   logic             w_pop;
   logic             w_clear;
   logic [SYM_W-1:0] w_head;

   assign w_active         = (r_state == S_ARM) || (r_state == S_STREAM);
   assign ap_if.ap_ready_o = w_active && !w_full;
   assign w_accept         = ap_if.ap_valid_i && ap_if.ap_ready_o;
   assign w_arm            = (r_state == S_IDLE) && enable_i;

`ifdef LTL_ENC_DEDUP_EN
   logic             r_last_vld;
   logic [SYM_W-1:0] r_last;

   assign w_push = w_accept && !(r_last_vld && (ap_if.ap_i == r_last));

   // Last-enqueued vector; invalidated on arm so the first vector always enters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last_vld <= 1'b0;
         r_last     <= '0;
      end else if (w_arm) begin
         r_last_vld <= 1'b0;
      end else if (w_push) begin
         r_last_vld <= 1'b1;
         r_last     <= ap_if.ap_i;
      end
   end
`else
   assign w_push = w_accept;
`endif

   ltl_sym_fifo #(.DEPTH(DEPTH), .SYM_W(SYM_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (w_clear),
      .push  (w_push),
      .pop   (w_pop),
      .wdata (ap_if.ap_i),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   // Next-state and pop/clear decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable_i) w_state_nxt = S_ARM;
         end
         S_ARM: begin
            if (flush_i) begin
               w_state_nxt = S_IDLE;
               w_clear     = 1'b1;
            end else if ((r_rst_cnt >= CNT_W'(RST_CYCLES - 1)) && !w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            w_pop = !w_empty;
            if (flush_i || !enable_i) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            w_pop = !w_empty;
            if (w_empty) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Registered automaton drive: reset held through IDLE/ARM, symbol updated only on pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_aut_reset <= 1'b1;
         r_aut_run   <= 1'b0;
         r_aut_sym   <= '0;
      end else begin
         r_aut_reset <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ARM);
         r_aut_run   <= w_pop;
         if (w_pop) r_aut_sym <= w_head;
      end
   end

   // Arm bookkeeping: reset-hold counter, delivered-symbol counter, sticky overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rst_cnt <= '0;
         r_sym_cnt <= '0;
         r_ovf     <= 1'b0;
      end else if (w_arm) begin
         r_rst_cnt <= '0;
         r_sym_cnt <= '0;
         r_ovf     <= 1'b0;
      end else begin
         if ((r_state == S_ARM) && (r_rst_cnt != '1)) r_rst_cnt <= r_rst_cnt + 1'b1;
         if (w_pop) r_sym_cnt <= r_sym_cnt + 1'b1;
         if (ap_if.ap_valid_i && w_active && w_full) r_ovf <= 1'b1;
      end
   end

   assign aut_reset_o   = r_aut_reset;
   assign aut_run_o     = r_aut_run;
   assign aut_symbols_o = r_aut_sym;
   assign busy_o        = (r_state != S_IDLE);
   assign ovf_o         = r_ovf;
   assign sym_count_o   = r_sym_cnt;
endmodule

// File: tb/tb_ltl_symbol_encoder.sv
// Scoreboard bench for ltl_symbol_encoder: two instances (short and long reset hold).
module tb_ltl_symbol_encoder;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic en_a  = 1'b0, fl_a = 1'b0, en_b = 1'b0, fl_b = 1'b0;

   logic        rst_a, run_a, busy_a, ovf_a;
   logic [7:0]  sym_a;
   logic [31:0] cnt_a;
   logic        rst_b, run_b, busy_b, ovf_b;
   logic [7:0]  sym_b;
   logic [31:0] cnt_b;

   ltl_symbol_encoder_if #(.SYM_W(8)) if_a ();
   ltl_symbol_encoder_if #(.SYM_W(8)) if_b ();

   always #5 clk = ~clk;

   ltl_symbol_encoder #(.DEPTH(8), .SYM_W(8), .RST_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset), .enable_i(en_a), .flush_i(fl_a), .ap_if(if_a.slave),
      .aut_reset_o(rst_a), .aut_run_o(run_a), .aut_symbols_o(sym_a),
      .busy_o(busy_a), .ovf_o(ovf_a), .sym_count_o(cnt_a));

   ltl_symbol_encoder #(.DEPTH(8), .SYM_W(8), .RST_CYCLES(16)) dut_b (
      .clk(clk), .reset(reset), .enable_i(en_b), .flush_i(fl_b), .ap_if(if_b.slave),
      .aut_reset_o(rst_b), .aut_run_o(run_b), .aut_symbols_o(sym_b),
      .busy_o(busy_b), .ovf_o(ovf_b), .sym_count_o(cnt_b));

   int n_chk = 0;
   int n_err = 0;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   int runs_a = 0;
   int runs_b = 0;
   logic [7:0] last_a = 8'h00;
   logic       last_vld_a = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: compare deliveries, then record vectors accepted at the coming edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (run_a) begin
            runs_a++;
            check("sbA_nonempty", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) check("sbA_sym", 32'(sym_a), 32'(q_a.pop_front()));
         end
         if (run_b) begin
            runs_b++;
            check("sbB_nonempty", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) check("sbB_sym", 32'(sym_b), 32'(q_b.pop_front()));
         end
         if (if_a.ap_valid_i && if_a.ap_ready_o) begin
`ifdef LTL_ENC_DEDUP_EN
            if (!(last_vld_a && (if_a.ap_i == last_a))) q_a.push_back(if_a.ap_i);
            last_a     = if_a.ap_i;
            last_vld_a = 1'b1;
`else
            q_a.push_back(if_a.ap_i);
`endif
         end
         if (if_b.ap_valid_i && if_b.ap_ready_o) q_b.push_back(if_b.ap_i);
      end
   end

   initial begin
      logic [7:0] stream_v [4];
      logic [7:0] drain_v [3];
      int base;
      stream_v = '{8'h00, 8'h40, 8'h80, 8'hFF};
      drain_v  = '{8'h11, 8'h22, 8'h33};
      if_a.ap_valid_i = 1'b0; if_a.ap_i = 8'h00;
      if_b.ap_valid_i = 1'b0; if_b.ap_i = 8'h00;

      #1 reset = 1'b1;
      #12;
      check("rst_aut_reset", 32'(rst_a), 32'd1);
      check("rst_run",       32'(run_a), 32'd0);
      check("rst_sym",       32'(sym_a), 32'd0);
      check("rst_ready",     32'(if_a.ap_ready_o), 32'd0);
      check("rst_busy",      32'(busy_a), 32'd0);
      check("rst_ovf",       32'(ovf_a), 32'd0);
      check("rst_cnt",       cnt_a, 32'd0);
      @(posedge clk); #2 reset = 1'b0;
      tick();

      // Arm: first symbol on the second edge after arming
      last_vld_a = 1'b0;
      en_a = 1'b1;
      tick();
      check("arm_busy",  32'(busy_a), 32'd1);
      check("arm_ready", 32'(if_a.ap_ready_o), 32'd1);
      if_a.ap_valid_i = 1'b1; if_a.ap_i = 8'h20;
      tick();
      if_a.ap_valid_i = 1'b0;
      check("arm_hold_reset", 32'(rst_a), 32'd1);
      check("arm_hold_run",   32'(run_a), 32'd0);
      tick();
      check("arm_release", 32'(rst_a), 32'd0);
      check("arm_run",     32'(run_a), 32'd1);
      check("arm_sym",     32'(sym_a), 32'h20);
      check("arm_cnt",     cnt_a, 32'd1);

      // Stream back to back, then a gap
      for (int i = 0; i < 4; i++) begin
         if_a.ap_valid_i = 1'b1; if_a.ap_i = stream_v[i];
         tick();
         if (i > 0) check("stream_run", 32'(run_a), 32'd1);
      end
      if_a.ap_valid_i = 1'b0;
      tick();
      check("stream_run_last", 32'(run_a), 32'd1);
      check("stream_sym_last", 32'(sym_a), 32'hFF);
      tick();
      check("gap_run",  32'(run_a), 32'd0);
      check("gap_hold", 32'(sym_a), 32'hFF);
      check("stream_cnt", cnt_a, 32'd5);

      // Drain: disable with the last of three pushes
      base = runs_a;
      for (int i = 0; i < 3; i++) begin
         if_a.ap_valid_i = 1'b1; if_a.ap_i = drain_v[i];
         if (i == 2) en_a = 1'b0;
         tick();
      end
      if_a.ap_valid_i = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (!busy_a) break;
         tick();
      end
      check("drain_idle",   32'(busy_a), 32'd0);
      check("drain_runs",   32'(runs_a - base), 32'd3);
      check("drain_reset",  32'(rst_a), 32'd1);
      check("drain_run",    32'(run_a), 32'd0);
      check("drain_ready",  32'(if_a.ap_ready_o), 32'd0);
      check("drain_cnt",    cnt_a, 32'd8);

      // Overflow while held in ARM by the long reset hold
      en_b = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) begin
         check("ovf_ready", 32'(if_b.ap_ready_o), (i < 8) ? 32'd1 : 32'd0);
         if_b.ap_valid_i = 1'b1; if_b.ap_i = 8'(8'h80 + i);
         tick();
      end
      if_b.ap_valid_i = 1'b0;
      check("ovf_flag",      32'(ovf_b), 32'd1);
      check("ovf_still_arm", 32'(rst_b), 32'd1);
      for (int k = 0; k < 40; k++) tick();
      check("ovf_runs", 32'(runs_b), 32'd8);
      check("ovf_cnt",  cnt_b, 32'd8);
      en_b = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (!busy_b) break;
         tick();
      end
      check("ovf_idle", 32'(busy_b), 32'd0);
      en_b = 1'b1;
      tick();
      check("rearm_ovf", 32'(ovf_b), 32'd0);
      check("rearm_cnt", cnt_b, 32'd0);

      // Flush in ARM discards queued vectors
      if_b.ap_valid_i = 1'b1; if_b.ap_i = 8'h01;
      tick();
      if_b.ap_i = 8'h02;
      tick();
      if_b.ap_valid_i = 1'b0;
      fl_b = 1'b1; en_b = 1'b0;
      tick();
      fl_b = 1'b0;
      q_b.delete();
      check("flush_busy",  32'(busy_b), 32'd0);
      check("flush_reset", 32'(rst_b), 32'd1);
      base = runs_b;
      en_b = 1'b1;
      tick();
      if_b.ap_valid_i = 1'b1; if_b.ap_i = 8'h03;
      tick();
      if_b.ap_valid_i = 1'b0;
      for (int k = 0; k < 30; k++) tick();
      check("flush_runs", 32'(runs_b - base), 32'd1);
      en_b = 1'b0;
      for (int k = 0; k < 10; k++) tick();

      // Asynchronous reset mid-stream
      last_vld_a = 1'b0;
      en_a = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         if_a.ap_valid_i = 1'b1; if_a.ap_i = 8'(8'h55 + 8'h11 * i);
         tick();
      end
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      check("areset_aut_reset", 32'(rst_a), 32'd1);
      check("areset_run",       32'(run_a), 32'd0);
      check("areset_sym",       32'(sym_a), 32'd0);
      check("areset_busy",      32'(busy_a), 32'd0);
      check("areset_cnt",       cnt_a, 32'd0);
      if_a.ap_valid_i = 1'b0;
      en_a = 1'b0;
      q_a.delete();
      q_b.delete();
      @(posedge clk); #2 reset = 1'b0;
      tick();
      base = runs_a;
      last_vld_a = 1'b0;
      en_a = 1'b1;
      tick();
      if_a.ap_valid_i = 1'b1; if_a.ap_i = 8'hA1;
      tick();
      if_a.ap_i = 8'hA2;
      tick();
      if_a.ap_valid_i = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      check("rearm_runs", 32'(runs_a - base), 32'd2);
      check("rearm_cnt_a", cnt_a, 32'd2);

`ifdef LTL_ENC_DEDUP_EN
      // Stutter compression
      en_a = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      base = runs_a;
      last_vld_a = 1'b0;
      en_a = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         if_a.ap_valid_i = 1'b1; if_a.ap_i = (i == 2) ? 8'h41 : 8'h40;
         tick();
      end
      if_a.ap_valid_i = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      check("dedup_runs", 32'(runs_a - base), 32'd2);
      check("dedup_cnt",  cnt_a, 32'd2);
`endif

      check("final_qa_empty", 32'(q_a.size()), 32'd0);
      check("final_qb_empty", 32'(q_b.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/ltl_symbol_encoder.md
Name: ltl_symbol_encoder

Overview:
- Producer side of the runtime-monitor symbol interface.
- Each cycle it samples an 8-bit atomic-proposition vector from the CVA6 core, buffers it in a small FIFO, and drives the automaton's reset/run/symbols inputs.
- Sequences the automaton's reset so the first buffered symbol lands exactly on the automaton's one-cycle start-of-data window.
- One instance feeds one monitor cluster.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- SYM_W, 8, symbol width; bit i = atomic proposition i.
- RST_CYCLES, 2, minimum cycles aut_reset_o is held high before streaming; >= 1.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- enable_i  input  1  arm the monitor; level-sensitive.
- flush_i  input  1  one-cycle pulse: stop accepting, drain the FIFO, return to idle.
- ap_valid_i  input  1  proposition vector valid.
- ap_i  input  SYM_W  proposition vector.
- ap_ready_o  output  1  encoder accepts ap_i this cycle.
- aut_reset_o  output  1  automaton reset.
- aut_run_o  output  1  automaton consumes aut_symbols_o this cycle.
- aut_symbols_o  output  SYM_W  symbol to automaton.
- busy_o  output  1  state != S_IDLE.
- ovf_o  output  1  sticky: a valid vector was dropped while the FIFO was full.
- sym_count_o  output  32  symbols delivered since the last arm; wraps at 2^32.

Behaviour:
- Reset values: aut_reset_o=1, aut_run_o=0, aut_symbols_o=0, ap_ready_o=0, busy_o=0, ovf_o=0, sym_count_o=0; FIFO empty; state S_IDLE.
- All aut_* outputs are registered. The automaton sees them one cycle after the encoder decides.
- Accept rule:
  - Enqueue when ap_valid_i && ap_ready_o.
  - ap_ready_o = (state is S_ARM or S_STREAM) && !full.
  - ap_valid_i high while state is S_ARM/S_STREAM and full: the vector is dropped and ovf_o sets. ovf_o clears only on reset or when S_IDLE -> S_ARM.
- FSM:
  - S_IDLE: aut_reset_o=1, aut_run_o=0. On enable_i=1 go to S_ARM; clear sym_count_o, ovf_o and the reset counter.
  - S_ARM: aut_reset_o stays 1. Leave only when the reset counter >= RST_CYCLES-1 and the FIFO is non-empty. On that edge, in the same edge:
    - aut_reset_o <= 0
    - aut_run_o <= 1
    - aut_symbols_o <= FIFO head (popped)
    - go to S_STREAM
    - This places the first symbol in the automaton's start_of_data cycle.
  - S_STREAM: each cycle the FIFO is non-empty, pop the head into aut_symbols_o with aut_run_o=1. When empty, aut_run_o=0 and aut_symbols_o holds its last value (automaton stalls). enable_i=0 goes to S_DRAIN.
  - S_DRAIN: ap_ready_o=0. Keep popping as in S_STREAM. When the FIFO is empty and no pop is occurring, go to S_IDLE; aut_reset_o <= 1 and aut_run_o <= 0 on that edge.
  - flush_i in S_ARM: go to S_IDLE directly and clear the FIFO.
  - flush_i in S_STREAM: go to S_DRAIN.
  - flush_i in S_IDLE or S_DRAIN: ignored.
- Simultaneous push and pop: allowed when full or empty. Pop-then-push on empty is not bypassed; the symbol appears one cycle later. Push on full with a same-cycle pop is accepted.
- sym_count_o increments on every cycle aut_run_o is registered 1.
- Asynchronous reset mid-stream returns to reset values immediately; FIFO contents are discarded.
- Latency, ap_i to aut_symbols_o in S_STREAM with empty FIFO: 2 cycles (enqueue edge, pop edge).

Optional Feature:
- Macro: LTL_ENC_DEDUP_EN.
- Defined:
  - A valid vector equal to the last enqueued vector is consumed (ap_ready_o still honoured) but not enqueued. This is stutter compression.
  - The last-vector register is invalidated on S_IDLE -> S_ARM, so the first vector is always enqueued.
- Undefined: every accepted vector is enqueued. No comparator or register exists.

Decomposition:
- Package ltl_enc_pkg:
  - state enum enc_state_e {S_IDLE, S_ARM, S_STREAM, S_DRAIN}
  - localparam SYM_W_DEF = 8
  - localparam CNT_W = 32
- Sub-module ltl_sym_fifo: synchronous FIFO with parameters DEPTH and SYM_W.
  - Ports: push, pop, wdata, rdata, full, empty, clear.
  - Pointers are log2(DEPTH)+1 bits wide, using the wrap bit for full/empty.

Test Plan:
- Arm: enable_i=1, push 0x20 at cycle 0 -> aut_reset_o falls on the edge at cycle max(RST_CYCLES,2) with aut_run_o=1 and aut_symbols_o=0x20; sym_count_o=1 the next cycle.
- Stream: push 0x00, 0x40, 0x80, 0xFF back to back -> same order on aut_symbols_o with run high four consecutive cycles; a gap in the input gives run=0 with the symbol held.
- Overflow: stall the automaton path by staying in S_ARM with RST_CYCLES=16, push DEPTH+1 vectors -> ap_ready_o=0 after DEPTH pushes, ovf_o=1, extra vector lost, DEPTH symbols delivered.
- Drain: enable_i=0 with 3 queued -> 3 run cycles, then aut_reset_o=1 and busy_o=0; a new arm clears ovf_o and sym_count_o.
- Async reset asserted mid-stream between edges -> outputs take reset values before the next edge; re-arm delivers only new vectors.
- With LTL_ENC_DEDUP_EN: push 0x40, 0x40, 0x41 -> only 0x40, 0x41 delivered; sym_count_o=2.
